// File: rtl/pipe_adder_n_if.sv
// Handshake bundle for pipe_adder_n: operand side (in_*) and result side (out_*).
interface pipe_adder_n_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   // Adder side of the bundle
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );

   // Producer/consumer side of the bundle
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipe_adder_n.sv
// Pipelined ripple-carry adder/subtractor. The WIDTH-bit add is cut into STAGES
// chunks of CW bits; stage k resolves chunk k and hands its carry to stage k+1.
// Each stage carries the operands forward so later chunks are still available,
// and the partial sum accumulates chunk by chunk. Stall logic lets bubbles
// collapse so the pipe holds up to STAGES ops and runs at one op per clock.
module pipe_adder_n #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic          clk,
   input  logic          rst,
   pipe_adder_n_if.slave bus
);
   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipe_adder_n: WIDTH must be a positive multiple of STAGES");
   end

   // Per-stage state: operands (b already conditioned for subtract), running
   // sum, carry out of the chunk resolved in that stage, and valid.
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic             adv [STAGES];

   // Stage k may load when some stage at or beyond k is empty, or the output drains.
   // Computed as a suffix-AND of valids so no combinational chain runs between stages.
   always_comb begin
      logic full;
      full = 1'b1;
      for (int k = LAST; k >= 0; k--) begin
         full   = full & v_q[k];
         adv[k] = bus.out_ready | ~full;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_x;
      logic [WIDTH-1:0] b_x;
      logic [WIDTH-1:0] s_x;
      logic             c_x;
      logic             v_x;
      logic [CW:0]      chunk;
      logic [WIDTH-1:0] s_d;

      if (k == 0) begin : g_first
         // Subtract is a + ~b + 1, with the borrow-in folded into the carry-in.
         assign a_x = bus.a;
         assign b_x = bus.sub ? ~bus.b : bus.b;
         assign c_x = bus.cin ^ bus.sub;
         assign s_x = '0;
         assign v_x = bus.in_valid;
      end else begin : g_next
         assign a_x = a_q[k-1];
         assign b_x = b_q[k-1];
         assign c_x = c_q[k-1];
         assign s_x = s_q[k-1];
         assign v_x = v_q[k-1];
      end

      assign chunk = {1'b0, a_x[k*CW +: CW]} + {1'b0, b_x[k*CW +: CW]} + {{CW{1'b0}}, c_x};

      // Merge this stage's chunk result into the running sum
      always_comb begin
         s_d              = s_x;
         s_d[k*CW +: CW]  = chunk[CW-1:0];
      end

      // Stage register: valid moves on every advance, data only when a real op arrives
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end else if (adv[k]) begin
            v_q[k] <= v_x;
            if (v_x) begin
               a_q[k] <= a_x;
               b_q[k] <= b_x;
               s_q[k] <= s_d;
               c_q[k] <= chunk[CW];
            end
         end
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = v_q[LAST];
   assign bus.sum       = s_q[LAST];
   assign bus.cout      = c_q[LAST];
   // Carry into the MSB is recovered as a^b^sum at that bit; overflow is it XOR carry-out.
   assign bus.ovf       = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_q[LAST][WIDTH-1] ^ c_q[LAST];
endmodule

// File: tb/tb_pipe_adder_n.sv
// Scoreboard bench for pipe_adder_n (WIDTH=16, STAGES=4).
module tb_pipe_adder_n;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   logic [17:0] exp_q [$];

   pipe_adder_n_if #(.WIDTH(16)) bus ();

   pipe_adder_n #(.WIDTH(16), .STAGES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: {ovf, cout, sum}
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
      logic [15:0] bb;
      logic [16:0] r;
      logic        o;
      bb = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {16'd0, cin ^ sub};
      o  = (a[15] == bb[15]) && (r[15] != a[15]);
      return {o, r[16], r[15:0]};
   endfunction

   // Output side of the scoreboard: a transfer happens at the next rising edge
   always @(negedge clk) begin
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", {31'd0, bus.out_valid}, 32'd0);
         end else begin
            chk("result", {14'd0, bus.ovf, bus.cout, bus.sum}, {14'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      bus.a   = a;
      bus.b   = b;
      bus.cin = cin;
      bus.sub = sub;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input logic [17:0] e);
      bit got;
      got = 1'b0;
      set_op(a, b, cin, sub);
      bus.in_valid = 1'b1;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(e);
            got = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!got) chk("send_timeout", {31'd0, bus.in_ready}, 32'd1);
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      chk("drain_left", exp_q.size(), 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rc, rs, pend;
      int          idx, acc;

      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      set_op(16'h0, 16'h0, 1'b0, 1'b0);

      // Reset asserted mid-cycle: outputs clear without a clock edge
      #23 rst = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_sum",       {16'd0, bus.sum},       32'd0);
      chk("rst_cout",      {31'd0, bus.cout},      32'd0);
      chk("rst_ovf",       {31'd0, bus.ovf},       32'd0);
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      #2 rst = 1'b0;
      #1;
      chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("post_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      @(posedge clk); #1;

      // Latency: accept at edge N, out_valid visible after edge N+3
      bus.out_ready = 1'b1;
      set_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("lat_in_ready", {31'd0, bus.in_ready}, 32'd1);
            exp_q.push_back({1'b0, 1'b1, 16'h0000});
         end
         chk($sformatf("lat_ov_c%0d", c), {31'd0, bus.out_valid}, {31'd0, (c == 4)});
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end

      // Add / subtract corners
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
      send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
      send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
      send(16'h0000, 16'h0000, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFF});
      send(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});
      drain();

      // Streaming: 8 back-to-back ops, results on 8 consecutive cycles
      for (int c = 0; c < 13; c++) begin
         if (c < 8) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rs = 1'($urandom);
            set_op(ra, rb, rc, rs);
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         if (c < 8) begin
            chk("st_in_ready", {31'd0, bus.in_ready}, 32'd1);
            exp_q.push_back(model(ra, rb, rc, rs));
         end
         chk($sformatf("st_ov_c%0d", c), {31'd0, bus.out_valid}, {31'd0, (c >= 4 && c < 12)});
         @(posedge clk); #1;
      end
      chk("st_empty", exp_q.size(), 32'd0);

      // Backpressure: out_ready low for 10 cycles -> 4 accepted, output frozen
      bus.out_ready = 1'b0;
      idx = 0;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      for (int c = 0; c < 10; c++) begin
         set_op(ra, rb, rc, rs);
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(model(ra, rb, rc, rs));
            idx++;
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         end
         if (c >= 4) begin
            chk("bp_hold_ov",  {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_res", {14'd0, bus.ovf, bus.cout, bus.sum}, {14'd0, exp_q[0]});
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("bp_accepted", idx, 32'd4);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         send(ra, rb, rc, rs, model(ra, rb, rc, rs));
      end
      drain();

      // Reset mid-stream with 3 ops in flight
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
         send(ra, rb, rc, rs, model(ra, rb, rc, rs));
      end
      @(posedge clk); #1;
      chk("pre_rst_ov", {31'd0, bus.out_valid}, 32'd1);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_rst_ov",       {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_sum",      {16'd0, bus.sum},       32'd0);
      chk("mid_rst_in_ready", {31'd0, bus.in_ready},  32'd1);
      @(posedge clk); #3;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("after_rst_ov", {31'd0, bus.out_valid}, 32'd0);
         @(posedge clk); #1;
      end

      // Random traffic: 10k ops with random in_valid / out_ready
      acc  = 0;
      pend = 1'b0;
      for (int cyc = 0; cyc < 60000 && acc < 10000; cyc++) begin
         bus.out_ready = ($urandom_range(3) != 0);
         if (!pend && $urandom_range(3) != 0) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            pend = 1'b1;
         end
         set_op(ra, rb, rc, rs);
         bus.in_valid = pend;
         @(negedge clk);
         if (pend && bus.in_ready) begin
            exp_q.push_back(model(ra, rb, rc, rs));
            pend = 1'b0;
            acc++;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      chk("rand_accepted", acc, 32'd10000);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
